// File: rtl/disp_vramrd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_vramrd_pkg
// Purpose  : Shared types and constants for the display VRAM read engine.
//            FSM state encoding, AXI burst/response codes and a
//            constant-evaluable clog2 helper.
// Revision : 1.0 - initial release
// ============================================================================
package disp_vramrd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_vramrd_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_vramrd_if
// Purpose  : AXI read-address / read-response channel bundle between the
//            VRAM read engine (master) and the memory fabric (slave).
//            Read data itself is routed to the display buffer elsewhere.
// Ports    : araddr/arlen/arsize/arburst/arvalid/arready (AR channel)
//            rvalid/rlast/rresp/rready (R channel control)
// Revision : 1.0 - initial release
// ============================================================================
interface disp_vramrd_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rvalid, rlast, rresp
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rvalid, rlast, rresp
    );
endinterface
`default_nettype wire

// File: rtl/disp_vramrd_addrgen.sv
`default_nettype none
// ============================================================================
// Module   : disp_vramrd_addrgen
// Purpose  : Line/burst counters and burst address generator for one frame.
//            load_i latches the frame geometry; adv_i steps to the next
//            burst. Address arithmetic is 29-bit and wraps.
// Ports    : clk_i, rst_i (async, active high), load_i, adv_i, base_i,
//            pitch_i, hpixels_i, vlines_i -> addr_o, empty_o, last_o
// Revision : 1.0 - initial release
// ============================================================================
module disp_vramrd_addrgen #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 16,
    parameter int DIM_W     = 12
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              load_i,
    input  wire logic              adv_i,
    input  wire logic [28:0]       base_i,
    input  wire logic [28:0]       pitch_i,
    input  wire logic [DIM_W-1:0]  hpixels_i,
    input  wire logic [DIM_W-1:0]  vlines_i,
    output logic      [28:0]       addr_o,
    output logic                   empty_o,
    output logic                   last_o
);
    localparam int                 BPB    = BURST_LEN * DATA_W / 8;
    localparam logic [DIM_W+1:0]   BPB_W  = (DIM_W+2)'(BPB);
    localparam logic [28:0]        BPB_A  = 29'(BPB);
    localparam logic [DIM_W+1:0]   ONE_B  = (DIM_W+2)'(1);
    localparam logic [DIM_W-1:0]   ONE_L  = DIM_W'(1);

    logic [DIM_W+1:0] bpl_q, bpl_d, burst_q, burst_d;
    logic [DIM_W-1:0] line_q, line_d, vlines_q, vlines_d;
    logic [28:0]      addr_q, addr_d, line_base_q, line_base_d, pitch_q, pitch_d;
    logic [DIM_W+1:0] w_bpl;
    logic             w_eol;

    // Partial trailing bursts are simply dropped by the integer divide.
    assign w_bpl   = {hpixels_i, 2'b00} / BPB_W;
    assign empty_o = (w_bpl == '0) || (vlines_i == '0);
    assign w_eol   = (burst_q == bpl_q - ONE_B);
    assign last_o  = w_eol && (line_q == vlines_q - ONE_L);
    assign addr_o  = addr_q;

    always_comb begin
        bpl_d       = bpl_q;
        vlines_d    = vlines_q;
        pitch_d     = pitch_q;
        burst_d     = burst_q;
        line_d      = line_q;
        addr_d      = addr_q;
        line_base_d = line_base_q;
        if (load_i) begin
            bpl_d       = w_bpl;
            vlines_d    = vlines_i;
            pitch_d     = pitch_i;
            burst_d     = '0;
            line_d      = '0;
            addr_d      = base_i;
            line_base_d = base_i;
        end else if (adv_i) begin
            if (w_eol) begin
                burst_d     = '0;
                line_d      = line_q + ONE_L;
                line_base_d = line_base_q + pitch_q;
                addr_d      = line_base_q + pitch_q;
            end else begin
                burst_d = burst_q + ONE_B;
                addr_d  = addr_q + BPB_A;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bpl_q       <= '0;
            vlines_q    <= '0;
            pitch_q     <= '0;
            burst_q     <= '0;
            line_q      <= '0;
            addr_q      <= '0;
            line_base_q <= '0;
        end else begin
            bpl_q       <= bpl_d;
            vlines_q    <= vlines_d;
            pitch_q     <= pitch_d;
            burst_q     <= burst_d;
            line_q      <= line_d;
            addr_q      <= addr_d;
            line_base_q <= line_base_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/disp_vramrd.sv
`default_nettype none
// ============================================================================
// Module   : disp_vramrd
// Purpose  : Parametrised VRAM read engine. Walks one frame in INCR bursts,
//            keeping up to MAX_OUTST bursts in flight, gated by buffer
//            readiness. Owns the FSM and the outstanding-burst counter.
// Ports    : clk_i, rst_i (async, active high), vrstart_i, dispon_i,
//            dispaddr_i, hpixels_i, vlines_i, stride_i (optional),
//            buf_wready_i, axi (master modport), busy_o, frame_done_o,
//            rd_err_o
// Config   : DISP_VRAMRD_STRIDE_EN - line pitch from stride_i; otherwise
//            pitch = hpixels*4 and stride_i is absent.
// Revision : 1.0 - initial release
// ============================================================================
module disp_vramrd
    import disp_vramrd_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 16,
    parameter int MAX_OUTST = 4,
    parameter int DIM_W     = 12
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              vrstart_i,
    input  wire logic              dispon_i,
    input  wire logic [28:0]       dispaddr_i,
    input  wire logic [DIM_W-1:0]  hpixels_i,
    input  wire logic [DIM_W-1:0]  vlines_i,
`ifdef DISP_VRAMRD_STRIDE_EN
    input  wire logic [15:0]       stride_i,
`endif
    input  wire logic              buf_wready_i,
    disp_vramrd_if.master          axi,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   rd_err_o
);
    localparam int               OUT_W = clog2(MAX_OUTST + 1);
    localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTST);
    localparam logic [OUT_W-1:0] ONE_O = OUT_W'(1);

    state_e           state_q, state_d;
    logic             arvalid_q, arvalid_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic             frame_done_q, frame_done_d;
    logic             rd_err_q, rd_err_d;
    logic             stop_q, stop_d;
    logic             w_load, w_ar_hs, w_r_beat, w_r_done, w_stopping;
    logic             w_empty, w_last;
    logic [28:0]      w_addr, w_pitch;

`ifdef DISP_VRAMRD_STRIDE_EN
    assign w_pitch = 29'(stride_i);
`else
    assign w_pitch = 29'({hpixels_i, 2'b00});
`endif

    disp_vramrd_addrgen #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .DIM_W     (DIM_W)
    ) u_addrgen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (w_load),
        .adv_i     (w_ar_hs),
        .base_i    (dispaddr_i),
        .pitch_i   (w_pitch),
        .hpixels_i (hpixels_i),
        .vlines_i  (vlines_i),
        .addr_o    (w_addr),
        .empty_o   (w_empty),
        .last_o    (w_last)
    );

    assign w_ar_hs  = arvalid_q & axi.arready;
    assign w_r_beat = axi.rvalid & axi.rready;
    // Beats with nothing outstanding belong to a burst issued before a reset
    // and are swallowed without touching the counter or the error flag.
    assign w_r_done   = w_r_beat & axi.rlast & (outst_q != '0);
    assign w_stopping = stop_q | vrstart_i | ~dispon_i;

    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        frame_done_d = 1'b0;
        stop_d       = stop_q;
        w_load       = 1'b0;
        outst_d      = outst_q;
        if (w_ar_hs && !w_r_done) begin
            outst_d = outst_q + ONE_O;
        end else if (!w_ar_hs && w_r_done) begin
            outst_d = outst_q - ONE_O;
        end
        rd_err_d = (vrstart_i ? 1'b0 : rd_err_q)
                 | (w_r_beat && (axi.rresp != AXI_RESP_OKAY) && (outst_q != '0));

        unique case (state_q)
            IDLE: begin
                stop_d    = 1'b0;
                arvalid_d = 1'b0;
                if (vrstart_i && dispon_i && !w_empty) begin
                    w_load  = 1'b1;
                    outst_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (vrstart_i || !dispon_i) begin
                    stop_d = 1'b1;
                end
                if (arvalid_q) begin
                    // A presented request is held until accepted, whatever
                    // happens to buffer readiness or the stop condition.
                    if (axi.arready) begin
                        if (w_last || w_stopping) begin
                            arvalid_d = 1'b0;
                            state_d   = DRAIN;
                        end else begin
                            arvalid_d = buf_wready_i && (outst_d < MAX_O);
                        end
                    end
                end else if (w_stopping) begin
                    state_d = DRAIN;
                end else begin
                    arvalid_d = buf_wready_i && (outst_q < MAX_O);
                end
            end
            DRAIN: begin
                arvalid_d = 1'b0;
                if (outst_q == '0) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            arvalid_q    <= 1'b0;
            outst_q      <= '0;
            frame_done_q <= 1'b0;
            rd_err_q     <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            outst_q      <= outst_d;
            frame_done_q <= frame_done_d;
            rd_err_q     <= rd_err_d;
            stop_q       <= stop_d;
        end
    end

    assign axi.araddr  = {3'b000, w_addr};
    assign axi.arlen   = 8'(BURST_LEN - 1);
    assign axi.arsize  = 3'(clog2(DATA_W / 8));
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = 1'b1;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frame_done_q;
    assign rd_err_o     = rd_err_q;
endmodule
`default_nettype wire

// File: tb/tb_disp_vramrd.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_vramrd
// Purpose  : Directed self-checking bench for disp_vramrd (MAX_OUTST=2).
//            A small AXI slave model answers AR requests with BURST_LEN
//            beats and counts handshakes, RLASTs and FRAME_DONE pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_vramrd;
    localparam int DATA_W    = 64;
    localparam int BURST_LEN = 16;
    localparam int MAX_OUTST = 2;
    localparam int DIM_W     = 12;

    logic             clk;
    logic             rst;
    logic             vrstart;
    logic             dispon;
    logic [28:0]      dispaddr;
    logic [DIM_W-1:0] hpixels;
    logic [DIM_W-1:0] vlines;
`ifdef DISP_VRAMRD_STRIDE_EN
    logic [15:0]      stride;
`endif
    logic             buf_wready;
    logic             busy;
    logic             frame_done;
    logic             rd_err;

    disp_vramrd_if axi ();

    disp_vramrd #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .MAX_OUTST (MAX_OUTST),
        .DIM_W     (DIM_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .vrstart_i    (vrstart),
        .dispon_i     (dispon),
        .dispaddr_i   (dispaddr),
        .hpixels_i    (hpixels),
        .vlines_i     (vlines),
`ifdef DISP_VRAMRD_STRIDE_EN
        .stride_i     (stride),
`endif
        .buf_wready_i (buf_wready),
        .axi          (axi),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .rd_err_o     (rd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_total = 0;
    int          n_bad   = 0;
    int          ar_cnt, rlast_cnt, fd_cnt, pend, beat;
    logic [31:0] ar_q[$];
    bit          ar_ready_en, r_en, err_arm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: drives at the falling edge and books the handshakes that
    // the following rising edge will complete.
    initial begin
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rresp   = 2'b00;
        pend = 0; beat = 0; ar_cnt = 0; rlast_cnt = 0; fd_cnt = 0;
        forever begin
            @(negedge clk);
            axi.arready = ar_ready_en;
            if (r_en && pend > 0) begin
                axi.rvalid = 1'b1;
                axi.rlast  = (beat == BURST_LEN - 1);
                axi.rresp  = err_arm ? 2'b10 : 2'b00;
                err_arm    = 1'b0;
            end else begin
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
                axi.rresp  = 2'b00;
            end
            if (axi.arvalid && axi.arready) begin
                ar_q.push_back(axi.araddr);
                ar_cnt++;
                pend++;
            end
            if (axi.rvalid && axi.rready) begin
                if (axi.rlast) begin
                    pend--;
                    beat = 0;
                    rlast_cnt++;
                end else begin
                    beat++;
                end
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        ar_cnt = 0; rlast_cnt = 0; fd_cnt = 0;
        ar_q.delete();
    endtask

    task automatic start_frame(input logic [28:0] base, input int h, input int v);
        dispaddr = base;
        hpixels  = DIM_W'(h);
        vlines   = DIM_W'(v);
        vrstart  = 1'b1;
        tick();
        vrstart  = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int target);
        for (int i = 0; i < 3000 && fd_cnt < target; i++) tick();
        check(tag, fd_cnt, target);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vrstart = 1'b0; dispon = 1'b1; dispaddr = '0;
        hpixels = '0; vlines = '0; buf_wready = 1'b1;
        ar_ready_en = 1'b1; r_en = 1'b1; err_arm = 1'b0;
`ifdef DISP_VRAMRD_STRIDE_EN
        stride = 16'h0;
`endif
        repeat (3) tick();
        check("rst_arvalid", 32'(axi.arvalid), 32'd0);
        check("rst_araddr", axi.araddr, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        check("rst_rready", 32'(axi.rready), 32'd1);
        rst = 1'b0;
        tick();

        // 64x4 frame: 2 bursts/line, contiguous, 8 ARs total.
        clear_counts();
        start_frame(29'h100_0000, 64, 4);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_arvalid_early", 32'(axi.arvalid), 32'd0);
        tick();
        check("lat_arvalid", 32'(axi.arvalid), 32'd1);
        check("first_araddr", axi.araddr, 32'h0100_0000);
        check("arlen", 32'(axi.arlen), 32'd15);
        check("arsize", 32'(axi.arsize), 32'd3);
        check("arburst", 32'(axi.arburst), 32'd1);
        wait_fd("frame1_done", 1);
        check("frame1_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check("frame1_ar_cnt", 32'(ar_cnt), 32'd8);
        check("frame1_fd_once", 32'(fd_cnt), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("frame1_addr%0d", k),
                  (k < ar_q.size()) ? ar_q[k] : 32'hDEAD_BEEF,
                  32'h0100_0000 + 32'(k) * 32'h80);
        end

        // ARREADY low: request must hold steady, no further AR.
        clear_counts();
        ar_ready_en = 1'b0;
        start_frame(29'h100_0000, 64, 4);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_arvalid", 32'(axi.arvalid), 32'd1);
            check("hold_araddr", axi.araddr, 32'h0100_0000);
            tick();
        end
        check("hold_ar_cnt", 32'(ar_cnt), 32'd0);
        ar_ready_en = 1'b1;
        wait_fd("hold_done", 1);
        check("hold_total_ar", 32'(ar_cnt), 32'd8);

        // Outstanding limit: no R data -> exactly MAX_OUTST ARs.
        clear_counts();
        r_en = 1'b0;
        start_frame(29'h100_0000, 64, 4);
        repeat (30) tick();
        check("outst_ar_cnt", 32'(ar_cnt), 32'd2);
        check("outst_arvalid", 32'(axi.arvalid), 32'd0);
        r_en = 1'b1;
        for (int i = 0; i < 200 && rlast_cnt < 1; i++) tick();
        check("outst_first_rlast", 32'(rlast_cnt), 32'd1);
        repeat (3) tick();
        check("outst_third_ar", 32'(ar_cnt), 32'd3);
        wait_fd("outst_done", 1);
        check("outst_total_ar", 32'(ar_cnt), 32'd8);

        // Overrun with a pending AR: it completes, then nothing more.
        clear_counts();
        ar_ready_en = 1'b0;
        start_frame(29'h100_0000, 64, 4);
        tick();
        vrstart = 1'b1;
        tick();
        vrstart = 1'b0;
        check("ovr_pending_arvalid", 32'(axi.arvalid), 32'd1);
        ar_ready_en = 1'b1;
        wait_fd("ovr_done", 1);
        check("ovr_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check("ovr_ar_cnt", 32'(ar_cnt), 32'd1);
        check("ovr_rlast_cnt", 32'(rlast_cnt), 32'd1);

        // DISPON low or empty geometry: VRSTART ignored.
        clear_counts();
        dispon = 1'b0;
        start_frame(29'h100_0000, 64, 4);
        check("nodisp_busy", 32'(busy), 32'd0);
        dispon = 1'b1;
        start_frame(29'h100_0000, 0, 4);
        check("zero_h_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("ignored_ar_cnt", 32'(ar_cnt), 32'd0);

        // Error response is sticky until the next VRSTART.
        clear_counts();
        err_arm = 1'b1;
        start_frame(29'h000_2000, 64, 1);
        wait_fd("err_frame_done", 1);
        check("err_set", 32'(rd_err), 32'd1);
        repeat (5) tick();
        check("err_sticky", 32'(rd_err), 32'd1);
        clear_counts();
        start_frame(29'h000_2000, 64, 1);
        check("err_cleared", 32'(rd_err), 32'd0);
        wait_fd("err_frame2_done", 1);
        check("err_stays_clear", 32'(rd_err), 32'd0);

`ifdef DISP_VRAMRD_STRIDE_EN
        // Strided frame: second line starts one pitch above the base.
        clear_counts();
        stride = 16'h0400;
        start_frame(29'h100_0000, 64, 2);
        wait_fd("stride_done", 1);
        check("stride_ar_cnt", 32'(ar_cnt), 32'd4);
        check("stride_addr2", (ar_q.size() > 2) ? ar_q[2] : 32'hDEAD_BEEF, 32'h0100_0400);
        check("stride_addr3", (ar_q.size() > 3) ? ar_q[3] : 32'hDEAD_BEEF, 32'h0100_0480);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
